mul_share_scheduler: RTL and testbench
======================================

// Module: mul_share_scheduler
// PURPOSE
//  Sequencer and arbiter for the shared repeated-addition multiplier datapath (A reg, B down-counter, P accumulator, eqz flag).
//  Accepts multiply requests from N clients, grants round-robin, drives the datapath load/clear/decrement strobes.
//  Returns the product with the requester's ID. One multiply in flight at a time.
// PARAMETERS
//  N   4  number of requesters (>=2)
//  W   8  operand width; product width PW=2*W, ID width IW=$clog2(N) (derived localparams)
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     synchronous reset, active low
//  req_valid   in   N     per-client request valid
//  req_a       in   N*W   per-client operand A, client i at [i*W +: W]
//  req_b       in   N*W   per-client operand B (iteration count)
//  req_ready   out  N     one-hot accept strobe; request taken on valid&ready
//  rsp_valid   out  1     product valid, held until rsp_ready
//  rsp_ready   in   1     consumer accepts response
//  rsp_id      out  IW    index of the client that owns rsp_data
//  rsp_data    out  PW    product, sampled from dp_prod
//  busy        out  1     high in every state except IDLE
//  dp_data     out  W     shared datapath input bus
//  dp_lda      out  1     load A from dp_data
//  dp_ldb      out  1     load B counter from dp_data
//  dp_clrp     out  1     clear P
//  dp_ldp      out  1     P <= P + A
//  dp_decb     out  1     B <= B - 1
//  dp_eqz      in   1     B==0 (combinational from datapath)
//  dp_prod     in   PW    P register value
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, rr pointer=0, all outputs 0, captured operands/ID 0.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> ITER -> RESP -> IDLE.
//  IDLE: arbitrate req_valid among clients. Round-robin from pointer; pointer <= grant+1 mod N on accept.
//   req_ready = grant one-hot (combinational, IDLE only). On accept, capture a, b, id; go LOAD_A.
//   No valid request: stay in IDLE, req_ready=0.
//  LOAD_A: dp_data=a, dp_lda=1.
//  LOAD_B: dp_data=b, dp_ldb=1, dp_clrp=1.
//  ITER: dp_ldp=dp_decb=(dp_eqz==0) (Mealy). Stay while eqz=0; on eqz=1 go RESP, no strobe.
//   b=0 therefore yields 0 with no additions.
//  RESP: rsp_valid=1, rsp_id=captured id, rsp_data=dp_prod (registered on RESP entry, stable while held).
//   On rsp_ready=1: go IDLE. On rsp_ready=0: hold all rsp_* outputs.
//  dp_data=0 and all dp_* strobes=0 outside the states listed above.
//  Latency: accept edge -> rsp_valid high = b_eff+4 cycles (LOAD_A, LOAD_B, b_eff+1 ITER, RESP).
//  New request accepted at earliest the cycle after the response handshake (IDLE entry).
//  Non-granted requesters keep req_valid; their operands are not sampled until granted.
//  Arithmetic: no overflow possible (W x W fits in PW). Counter wrap belongs to the datapath and must never occur (decb gated by eqz).
//  Reset mid-operation: abandon job, no response issued, strobes low next cycle, pointer=0.
//  req_valid dropping after accept has no effect. rsp_ready high outside RESP is ignored.
// CONFIGURATION
//  MUL_OPERAND_SWAP_EN defined: at accept, if b>a swap operands so min(a,b) drives the counter; b_eff=min(a,b).
//   Product unchanged.
//  Undefined: operands used as given; b_eff=b.
// STRUCTURE
//  Package mul_sched_pkg: FSM state encoding (IDLE, LOAD_A, LOAD_B, ITER, RESP), default N/W constants.
//  Sub-module mul_rr_arbiter (N): inputs req[N], ptr, en; outputs grant one-hot, grant_idx.
//   Pointer register lives in the scheduler.
// TESTING
//  Single client 0: a=5,b=3 -> dp_ldp pulses 3 times, rsp_id=0, rsp_data=15, rsp_valid 7 cycles after accept.
//  b=0, a=200 -> no ldp/decb pulse, rsp_data=0, latency 4.
//   With MUL_OPERAND_SWAP_EN: a=2,b=100 -> 2 ldp pulses, rsp_data=200, latency 6.
//  All 4 clients valid continuously -> grants in order 0,1,2,3,0; each rsp_id matches.
//  rsp_ready held 0 for 10 cycles -> rsp_valid/id/data stable, req_ready stays 0, no strobes.
//  rst_n=0 during ITER (a=9,b=50) -> next cycle all outputs 0, no rsp_valid.
//   After release, client 2 request a=255,b=255 -> rsp_data=65025.
//  Max operands a=b=255 (swap off) -> exactly 255 ldp pulses, B never decremented past 0.

Source files
------------

// File: rtl/mul_share_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// mul_sched_pkg
// Shared definitions for the multiplier-sharing scheduler: the sequencer
// state encoding and the default requester count / operand width.
// ----------------------------------------------------------------------------
package mul_sched_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ITER,
        RESP
    } sched_state_t;

endpackage

// File: rtl/mul_share_scheduler_if.sv
// ----------------------------------------------------------------------------
// mul_share_scheduler_if
// Bundles the client request bus, the response bus and the shared
// repeated-addition datapath control/status signals.
//   req_valid/req_ready  per-client request handshake (N bits each)
//   req_a/req_b          per-client operands, client i at [i*W +: W]
//   rsp_*                product response with owning client id
//   busy                 scheduler not idle
//   dp_*                 shared datapath bus, strobes, eqz flag and product
// Modports: slave = scheduler side, master = clients + datapath side.
// ----------------------------------------------------------------------------
interface mul_share_scheduler_if
    import mul_sched_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*W-1:0]       req_a;
    logic [N*W-1:0]       req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [$clog2(N)-1:0] rsp_id;
    logic [2*W-1:0]       rsp_data;
    logic                 busy;
    logic [W-1:0]         dp_data;
    logic                 dp_lda;
    logic                 dp_ldb;
    logic                 dp_clrp;
    logic                 dp_ldp;
    logic                 dp_decb;
    logic                 dp_eqz;
    logic [2*W-1:0]       dp_prod;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, dp_eqz, dp_prod,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy,
               dp_data, dp_lda, dp_ldb, dp_clrp, dp_ldp, dp_decb
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, dp_eqz, dp_prod,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy,
               dp_data, dp_lda, dp_ldb, dp_clrp, dp_ldp, dp_decb
    );

endinterface

// File: rtl/mul_share_scheduler_arbiter.sv
// ----------------------------------------------------------------------------
// mul_rr_arbiter
// Combinational round-robin arbiter. Searches req starting at index ptr and
// grants the first active requester.
//   req        in   N   request vector
//   ptr        in   IW  highest-priority index for this search
//   en         in   1   enable; no grant when low
//   grant      out  N   one-hot grant
//   grant_idx  out  IW  index of the granted requester
// ----------------------------------------------------------------------------
module mul_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_share_scheduler.sv
// ----------------------------------------------------------------------------
// mul_share_scheduler
// Sequencer and round-robin arbiter for a shared repeated-addition
// multiplier datapath. One multiply in flight: IDLE -> LOAD_A -> LOAD_B ->
// ITER -> RESP -> IDLE.
//   clk    in  rising-edge clock
//   rst_n  in  synchronous reset, active low
//   bus    mul_share_scheduler_if.slave: requests, response, datapath control
// Optional feature: define MUL_OPERAND_SWAP_EN to put min(a,b) on the
// iteration counter (fewer additions, same product).
// ----------------------------------------------------------------------------
module mul_share_scheduler
    import mul_sched_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul_share_scheduler_if.slave  bus
);

    localparam int PW = 2 * W;
    localparam int IW = $clog2(N);

    sched_state_t   state;
    sched_state_t   state_nx;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  cap_id;
    logic [W-1:0]   cap_a;
    logic [W-1:0]   cap_b;
    logic [PW-1:0]  rsp_q;
    logic [N-1:0]   grant;
    logic [IW-1:0]  grant_idx;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

    mul_rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .en        (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A grant only exists in IDLE, so any grant bit is a completed handshake.
    assign accept = |grant;

    always_comb begin
        sel_a = bus.req_a[int'(grant_idx)*W +: W];
        sel_b = bus.req_b[int'(grant_idx)*W +: W];
`ifdef MUL_OPERAND_SWAP_EN
        // Smaller operand drives the counter so the add loop is shortest.
        if (sel_b > sel_a) begin
            sel_a = bus.req_b[int'(grant_idx)*W +: W];
            sel_b = bus.req_a[int'(grant_idx)*W +: W];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)        state_nx = LOAD_A;
            LOAD_A:                     state_nx = LOAD_B;
            LOAD_B:                     state_nx = ITER;
            ITER:    if (bus.dp_eqz)    state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // Job capture, round-robin pointer and the product snapshot. The product
    // is final on the ITER cycle where eqz is seen, since no add fires then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= '0;
            cap_id <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
            rsp_q  <= '0;
        end else begin
            if (accept) begin
                ptr    <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
                cap_id <= grant_idx;
                cap_a  <= sel_a;
                cap_b  <= sel_b;
            end
            if (state == ITER && bus.dp_eqz) begin
                rsp_q <= bus.dp_prod;
            end
        end
    end

    always_comb begin
        bus.req_ready = grant;
        bus.rsp_valid = 1'b0;
        bus.rsp_id    = '0;
        bus.rsp_data  = '0;
        bus.busy      = (state != IDLE);
        bus.dp_data   = '0;
        bus.dp_lda    = 1'b0;
        bus.dp_ldb    = 1'b0;
        bus.dp_clrp   = 1'b0;
        bus.dp_ldp    = 1'b0;
        bus.dp_decb   = 1'b0;
        unique case (state)
            LOAD_A: begin
                bus.dp_data = cap_a;
                bus.dp_lda  = 1'b1;
            end
            LOAD_B: begin
                bus.dp_data = cap_b;
                bus.dp_ldb  = 1'b1;
                bus.dp_clrp = 1'b1;
            end
            ITER: begin
                // Gating on eqz keeps the counter from ever wrapping below 0.
                bus.dp_ldp  = !bus.dp_eqz;
                bus.dp_decb = !bus.dp_eqz;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = cap_id;
                bus.rsp_data  = rsp_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_share_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mul_share_scheduler
// Self-checking bench for mul_share_scheduler (N=4, W=8). Provides a
// behavioural datapath (A reg, B counter, P accumulator), a table of directed
// jobs, a mid-operation reset sequence and randomized jobs checked against a
// round-robin / product / latency reference model.
// ----------------------------------------------------------------------------
module tb_mul_share_scheduler;

    typedef struct {
        logic [3:0]      mask;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        int              hold;
        int              exp_id;
        int              exp_prod;
        int              exp_lat;
        int              exp_ldp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vec_count  = 0;
    int miscompares = 0;
    int model_ptr  = 0;
    int wrap_count = 0;

    logic [7:0]  dp_a = '0;
    logic [7:0]  dp_b = '0;
    logic [15:0] dp_p = '0;

    mul_share_scheduler_if #(.N(4), .W(8)) bus ();

    mul_share_scheduler #(.N(4), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural shared datapath driven by the scheduler strobes.
    assign bus.dp_eqz  = (dp_b == 8'd0);
    assign bus.dp_prod = dp_p;

    always @(posedge clk) begin
        if (bus.dp_decb && dp_b == 8'd0) wrap_count <= wrap_count + 1;
        if (bus.dp_lda) dp_a <= bus.dp_data;
        if (bus.dp_ldb) dp_b <= bus.dp_data;
        else if (bus.dp_decb) dp_b <= dp_b - 8'd1;
        if (bus.dp_clrp) dp_p <= '0;
        else if (bus.dp_ldp) dp_p <= dp_p + 16'(dp_a);
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.req_valid = v.mask;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        checkOutput({tag, "_dp_data"}, 32'(bus.dp_data), 0);
        checkOutput({tag, "_strobes"},
                    32'({bus.dp_lda, bus.dp_ldb, bus.dp_clrp, bus.dp_ldp, bus.dp_decb}), 0);
        checkOutput({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
        checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    endtask

    function automatic vec_t mkVec(input int client, input int a, input int b, input int hold,
                                   input int prod, input int lat, input int ldp);
        vec_t v;
        v.mask         = 4'(1 << client);
        v.a            = '0;
        v.b            = '0;
        v.a[client]    = 8'(a);
        v.b[client]    = 8'(b);
        v.hold         = hold;
        v.exp_id       = client;
        v.exp_prod     = prod;
        v.exp_lat      = lat;
        v.exp_ldp      = ldp;
        return v;
    endfunction

    function automatic vec_t mkAll(input int id, input int prod, input int lat, input int ldp);
        vec_t v;
        v.mask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            v.a[i] = 8'(i + 3);
            v.b[i] = 8'(i + 1);
        end
        v.hold     = 0;
        v.exp_id   = id;
        v.exp_prod = prod;
        v.exp_lat  = lat;
        v.exp_ldp  = ldp;
        return v;
    endfunction

    function automatic int rrPick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    // Called at #1 after a rising edge with the scheduler in IDLE.
    task automatic runVector(input vec_t v, input string tag);
        int guard;
        int cyc;
        int ldp_n;
        int stray;
        int hold_bad;
        applyStimulus(v);
        #1;
        guard = 0;
        while (bus.req_ready == 4'b0 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({tag, "_grant"}, 32'(bus.req_ready), 32'(4'b1 << v.exp_id));
        @(posedge clk); #1;
        model_ptr = (v.exp_id + 1) % 4;
        bus.req_valid[v.exp_id] = 1'b0;
        cyc   = 1;
        ldp_n = 0;
        stray = 0;
        while (!bus.rsp_valid && cyc < v.exp_lat + 8) begin
            if (bus.dp_ldp) ldp_n++;
            if (bus.req_ready != 4'b0) stray++;
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
        checkOutput({tag, "_ldp_pulses"}, 32'(ldp_n), 32'(v.exp_ldp));
        checkOutput({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(v.exp_id));
        checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(v.exp_prod));
        checkOutput({tag, "_ready_while_busy"}, 32'(stray), 0);
        hold_bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (!(bus.rsp_valid && bus.rsp_data == 16'(v.exp_prod) && int'(bus.rsp_id) == v.exp_id
                  && bus.req_ready == 4'b0 && bus.dp_data == 8'd0
                  && {bus.dp_lda, bus.dp_ldb, bus.dp_clrp, bus.dp_ldp, bus.dp_decb} == 5'b0))
                hold_bad++;
        end
        if (v.hold > 0) checkOutput({tag, "_hold_stable"}, 32'(hold_bad), 0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checkOutput({tag, "_idle_after_rsp"}, 32'(bus.busy), 0);
    endtask

    initial begin
        vec_t dir_vecs[$];
        vec_t v;
        vec_t rv;
        int   guard;
        int   bad;
        int   beff;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        rst_n     = 1'b1;
        model_ptr = 0;

        // Directed jobs; ids follow the round-robin pointer from reset.
        dir_vecs.push_back(mkVec(0, 5, 3, 0, 15, 7, 3));
        dir_vecs.push_back(mkVec(1, 200, 0, 0, 0, 4, 0));
        v = mkVec(3, 12, 7, 10, 84, 11, 7);
        v.mask[0] = 1'b1;
        v.a[0]    = 8'd9;
        v.b[0]    = 8'd9;
        dir_vecs.push_back(v);
        dir_vecs.push_back(mkAll(0, 3, 5, 1));
        dir_vecs.push_back(mkAll(1, 8, 6, 2));
        dir_vecs.push_back(mkAll(2, 15, 7, 3));
        dir_vecs.push_back(mkAll(3, 24, 8, 4));
        dir_vecs.push_back(mkAll(0, 3, 5, 1));
        dir_vecs.push_back(mkVec(2, 255, 255, 0, 65025, 259, 255));
`ifdef MUL_OPERAND_SWAP_EN
        dir_vecs.push_back(mkVec(0, 2, 100, 0, 200, 6, 2));
`else
        dir_vecs.push_back(mkVec(0, 2, 100, 0, 200, 104, 100));
`endif

        foreach (dir_vecs[i]) runVector(dir_vecs[i], $sformatf("dir%0d", i));

        // Reset while iterating abandons the job.
        applyStimulus(mkVec(1, 9, 50, 0, 0, 0, 0));
        #1;
        guard = 0;
        while (bus.req_ready == 4'b0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("midrst_grant", 32'(bus.req_ready), 32'(4'b0010));
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("midrst_in_iter", 32'(bus.dp_ldp), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkIdle("midrst");
        rst_n     = 1'b1;
        model_ptr = 0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || bus.busy) bad++;
        end
        checkOutput("midrst_no_rsp", 32'(bad), 0);
        runVector(mkVec(2, 255, 255, 0, 65025, 259, 255), "post_rst");

        // Randomized jobs against the round-robin / arithmetic model.
        for (int n = 0; n < 40; n++) begin
            rv.mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                rv.a[i] = 8'($urandom_range(0, 255));
                rv.b[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 12));
            end
            rv.hold     = $urandom_range(0, 3);
            rv.exp_id   = rrPick(rv.mask, model_ptr);
            rv.exp_prod = int'(rv.a[rv.exp_id]) * int'(rv.b[rv.exp_id]);
            beff        = int'(rv.b[rv.exp_id]);
`ifdef MUL_OPERAND_SWAP_EN
            if (int'(rv.a[rv.exp_id]) < beff) beff = int'(rv.a[rv.exp_id]);
`endif
            rv.exp_lat  = beff + 4;
            rv.exp_ldp  = beff;
            runVector(rv, $sformatf("rnd%0d", n));
        end

        checkOutput("no_b_wrap", 32'(wrap_count), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
